// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizing for the register-unit arbiter slice.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEF_ADDR_W        = 4;
  localparam int DEF_DATA_W        = 8;
  localparam int NUM_REGS          = 16;
  localparam int DEF_ACCESS_CYCLES = 3;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from last+1, or lowest index when
// ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IDX_W-1:0] idx_o
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  // Scan high to low so the lowest set index is the final assignment.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_o    = '0;
        win_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end
`else
  // Scan offsets far to near so the requester closest after last wins.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      int k;
      k = int'(last_i) + off;
      if (k >= N_REQ) k = k - N_REQ;
      if (req_i[k]) begin
        win_o    = '0;
        win_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one single-port register unit among N_REQ requesters, one sequenced
// access at a time. Define ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          req_we_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic                      rf_load_o,
  output logic [ADDR_W-1:0]         rf_addr_o,
  output logic [DATA_W-1:0]         rf_data_in_o,
  input  logic [DATA_W-1:0]         rf_data_out_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(ACCESS_CYCLES + 2);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] DONE   = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rf_load_q, rf_load_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_in_q, rf_data_in_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .win_o  (win_onehot),
    .idx_o  (win_idx)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = done_q;
    rdata_d      = rdata_q;
    rf_load_d    = rf_load_q;
    rf_addr_d    = rf_addr_q;
    rf_data_in_d = rf_data_in_q;
    last_d       = last_q;
    widx_d       = widx_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d        = win_onehot;
          widx_d       = win_idx;
          rf_load_d    = req_we_i[win_idx];
          rf_addr_d    = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
          rf_data_in_d = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
          cnt_d        = CNT_W'(1);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // The unit samples load on exactly one edge; later cycles only settle.
        rf_load_d = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ACCESS_CYCLES)) begin
          rdata_d = rf_data_out_i;
          done_d  = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d     = '0;
        done_d    = '0;
        rf_addr_d = '0;
        last_d    = widx_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      rf_load_q    <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_in_q <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      widx_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      rf_load_q    <= rf_load_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_in_q <= rf_data_in_d;
      last_q       <= last_d;
      widx_q       <= widx_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = (state_q != IDLE);
  assign rf_load_o    = rf_load_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_data_in_o = rf_data_in_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x8 register unit
// (registered read). Expectations switch with ARB_FIXED_PRIO_EN.
module tb_regfile_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clock_i = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_i;
  logic [N-1:0]    req_we_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic [DW-1:0]   rdata_o;
  logic            busy_o;
  logic            rf_load_o;
  logic [AW-1:0]   rf_addr_o;
  logic [DW-1:0]   rf_data_in_o;
  logic [DW-1:0]   rf_data_out_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] gnt_seen;
  logic         multi_gnt;

  always #5 clock_i = ~clock_i;

  regfile_arbiter #(
    .N_REQ         (N),
    .ACCESS_CYCLES (3),
    .ADDR_W        (AW),
    .DATA_W        (DW)
  ) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .req_i         (req_i),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .gnt_o         (gnt_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o),
    .busy_o        (busy_o),
    .rf_load_o     (rf_load_o),
    .rf_addr_o     (rf_addr_o),
    .rf_data_in_o  (rf_data_in_o),
    .rf_data_out_i (rf_data_out_i)
  );

  // Register unit: write on load, registered read; never reset.
  logic [DW-1:0] regs [16];
  always @(posedge clock_i) begin
    if (rf_load_o) regs[rf_addr_o] <= rf_data_in_o;
    rf_data_out_i <= regs[rf_addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
    gnt_seen |= gnt_o;
    if ($countones(gnt_o) > 1) multi_gnt = 1'b1;
  endtask

  // Bounded wait for a done pulse; cyc reports edges taken (20 = timeout).
  task automatic wait_done(output int cyc, output logic [N-1:0] d, output logic [DW-1:0] rd);
    cyc = 0;
    d   = '0;
    rd  = '0;
    while (cyc < 20) begin
      step();
      cyc++;
      if (done_o != '0) begin
        d  = done_o;
        rd = rdata_o;
        break;
      end
    end
  endtask

  // Run n idle edges, collecting any gnt/done activity.
  task automatic watch_idle(input int n, output logic [N-1:0] g, output logic [N-1:0] d);
    g = '0;
    d = '0;
    for (int i = 0; i < n; i++) begin
      step();
      g |= gnt_o;
      d |= done_o;
    end
  endtask

  int            cyc;
  logic [N-1:0]  d;
  logic [DW-1:0] rd;
  logic [N-1:0]  g_any, d_any;
  logic [N-1:0]  alt_done [4];
  logic [DW-1:0] alt_data [4];

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'((i << 4) | (15 - i));
`ifdef ARB_FIXED_PRIO_EN
    alt_done = '{2'b01, 2'b01, 2'b01, 2'b01};
    alt_data = '{8'h2D, 8'h2D, 8'h2D, 8'h2D};
`else
    alt_done = '{2'b01, 2'b10, 2'b01, 2'b10};
    alt_data = '{8'h2D, 8'h96, 8'h2D, 8'h96};
`endif
    reset_i     = 1'b0;
    req_i       = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    gnt_seen    = '0;
    multi_gnt   = 1'b0;
    step();
    step();
    check_eq("rst_gnt", 32'(gnt_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_outs", {rf_load_o, 3'b0, rf_addr_o, rf_data_in_o, rdata_o}, 0);
    reset_i = 1'b1;
    step();

    // Write 0xA7 to address 5 from requester 0, with read-back.
    req_i = 2'b01; req_we_i = 2'b01;
    req_addr_i = {4'h0, 4'h5}; req_wdata_i = {8'h00, 8'hA7};
    step();
    check_eq("wr_gnt_e1", 32'(gnt_o), 32'h1);
    check_eq("wr_load_e1", 32'(rf_load_o), 1);
    check_eq("wr_addr_e1", 32'(rf_addr_o), 5);
    check_eq("wr_data_e1", 32'(rf_data_in_o), 32'hA7);
    check_eq("wr_busy_e1", 32'(busy_o), 1);
    step();
    check_eq("wr_load_e2", 32'(rf_load_o), 0);
    step();
    check_eq("wr_done_e3", 32'(done_o), 0);
    step();
    check_eq("wr_done_e4", 32'(done_o), 32'h1);
    check_eq("wr_gnt_e4", 32'(gnt_o), 32'h1);
    check_eq("wr_rdata_e4", 32'(rdata_o), 32'hA7);
    req_i = '0; req_we_i = '0;
    step();
    check_eq("wr_idle_gnt", 32'(gnt_o), 0);
    check_eq("wr_idle_busy", 32'(busy_o), 0);
    check_eq("wr_idle_addr", 32'(rf_addr_o), 0);

    // Read address 5 from requester 1; address change after grant is ignored.
    gnt_seen = '0;
    req_i = 2'b10; req_addr_i = {4'h5, 4'h0};
    step();
    req_addr_i = {4'h0, 4'h0};
    wait_done(cyc, d, rd);
    check_eq("rd1_cyc", 32'(cyc + 1), 4);
    check_eq("rd1_done", 32'(d), 32'h2);
    check_eq("rd1_rdata", 32'(rd), 32'hA7);
    check_eq("rd1_gnt_seen", 32'(gnt_seen), 32'h2);
    req_i = '0;
    step();

    // Both requesters held, reading distinct addresses.
    gnt_seen = '0; multi_gnt = 1'b0;
    req_i = 2'b11; req_we_i = '0; req_addr_i = {4'h9, 4'h2};
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc, d, rd);
      check_eq($sformatf("alt%0d_cyc", i), 32'(cyc), (i == 0) ? 4 : 5);
      check_eq($sformatf("alt%0d_done", i), 32'(d), 32'(alt_done[i]));
      check_eq($sformatf("alt%0d_rdata", i), 32'(rd), 32'(alt_data[i]));
    end
    req_i = '0;
    check_eq("alt_onehot", 32'(multi_gnt), 0);
    step();
    step();

    // Requester 1 reads address 3 and drops req in the second access cycle.
    req_i = 2'b10; req_addr_i = {4'h3, 4'h0};
    step();
    step();
    req_i = '0;
    wait_done(cyc, d, rd);
    check_eq("drop_cyc", 32'(cyc + 2), 4);
    check_eq("drop_done", 32'(d), 32'h2);
    check_eq("drop_rdata", 32'(rd), 32'h3C);
    watch_idle(6, g_any, d_any);
    check_eq("drop_after_gnt", 32'(g_any), 0);
    check_eq("drop_after_done", 32'(d_any), 0);

    // Reset while the write to address 7 is in its first access cycle.
    req_i = 2'b01; req_we_i = 2'b01;
    req_addr_i = {4'h0, 4'h7}; req_wdata_i = {8'h00, 8'h5A};
    step();
    check_eq("rstmid_load", 32'(rf_load_o), 1);
    reset_i = 1'b0;
    step();
    check_eq("rstmid_gnt", 32'(gnt_o), 0);
    check_eq("rstmid_busy", 32'(busy_o), 0);
    check_eq("rstmid_load0", 32'(rf_load_o), 0);
    reset_i = 1'b1; req_i = '0; req_we_i = '0;
    watch_idle(6, g_any, d_any);
    check_eq("rstmid_no_done", 32'(d_any), 0);
    // The unit sampled load at the reset edge, so the write committed.
    req_i = 2'b10; req_addr_i = {4'h7, 4'h0};
    wait_done(cyc, d, rd);
    check_eq("rstmid_rd_done", 32'(d), 32'h2);
    check_eq("rstmid_rd_data", 32'(rd), 32'h5A);
    req_i = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
